mem_arbiter: RTL and testbench

- Shares one tagged unified memory between the IF stage (instruction loads only) and the MEM stage (data loads and stores).
- Uses fixed data-port priority, with a starvation guard so instruction fetch always makes progress.
- Tracks outstanding load tags so that returned memory data is routed to the requester that issued the load.
- Sits between the processor's pc_addr/im_command and proc2Dmem_* interfaces and a single mem instance.

---
 rtl/mem_arbiter_if.sv | 13 +
 rtl/mem_arbiter.sv | 95 +++++++++
 tb/tb_mem_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Tagged memory bus: the requester drives command/addr/wdata and gets back an accept tag,
// plus a return tag/data from the memory side.
interface mem_bus_if #(parameter int TAG_W = 4);
    logic [1:0]       command;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [TAG_W-1:0] response;
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;

    modport master (output command, addr, wdata, input  response, data, tag);
    modport slave  (input  command, addr, wdata, output response, data, tag);
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates IF and DM requests onto one tagged memory, with DM priority and a starvation
// guard for IF, and routes load returns back to the requester that owns each tag.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int NUM_TAGS     = 16
) (
    input  logic      clk,
    input  logic      rst,
    mem_bus_if.slave  if_bus,
    mem_bus_if.slave  dm_bus,
    mem_bus_if.master mem_bus,
    output logic      orphan_err
);
    localparam int TAG_W = $clog2(NUM_TAGS);
    localparam int CW    = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic [CW-1:0]       starve_cnt_q, starve_cnt_d;
    logic [NUM_TAGS-1:0] valid_q, valid_d;
    logic [NUM_TAGS-1:0] owner_q, owner_d;   // 0 = IF, 1 = DM
    logic                orphan_q, orphan_d;

    logic             if_req, dm_req, grant_if, grant_dm, accepted, ret_hit;
    logic [1:0]       win_cmd;
    logic [TAG_W-1:0] rtag, atag;

    always_comb begin
        if_req   = (if_bus.command == BUS_LOAD);
        dm_req   = (dm_bus.command == BUS_LOAD) || (dm_bus.command == BUS_STORE);
        grant_if = if_req && (!dm_req || (starve_cnt_q == CW'(STARVE_LIMIT)));
        grant_dm = dm_req && !grant_if;

        win_cmd        = BUS_NONE;
        mem_bus.addr   = '0;
        mem_bus.wdata  = '0;
        if (!rst && grant_if) begin
            win_cmd       = if_bus.command;
            mem_bus.addr  = if_bus.addr;
            mem_bus.wdata = if_bus.wdata;
        end else if (!rst && grant_dm) begin
            win_cmd       = dm_bus.command;
            mem_bus.addr  = dm_bus.addr;
            mem_bus.wdata = dm_bus.wdata;
        end
        mem_bus.command = win_cmd;

        atag     = mem_bus.response;
        accepted = !rst && (grant_if || grant_dm) && (atag != '0);
        if_bus.response = (!rst && grant_if) ? atag : '0;
        dm_bus.response = (!rst && grant_dm) ? atag : '0;

        rtag    = mem_bus.tag;
        ret_hit = !rst && (rtag != '0) && valid_q[rtag];
        if_bus.tag  = (ret_hit && !owner_q[rtag]) ? rtag : '0;
        if_bus.data = (ret_hit && !owner_q[rtag]) ? mem_bus.data : '0;
        dm_bus.tag  = (ret_hit &&  owner_q[rtag]) ? rtag : '0;
        dm_bus.data = (ret_hit &&  owner_q[rtag]) ? mem_bus.data : '0;

        // Clear on return first so a same-cycle accept of the same tag wins.
        valid_d = valid_q;
        owner_d = owner_q;
        if (ret_hit) valid_d[rtag] = 1'b0;
        if (accepted && win_cmd == BUS_LOAD) begin
            valid_d[atag] = 1'b1;
            owner_d[atag] = grant_dm;
        end

        orphan_d = orphan_q | ((rtag != '0) && !valid_q[rtag]);

        if (!if_req || (grant_if && atag != '0))
            starve_cnt_d = '0;
        else if (starve_cnt_q < CW'(STARVE_LIMIT))
            starve_cnt_d = starve_cnt_q + 1'b1;
        else
            starve_cnt_d = starve_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
            valid_q      <= '0;
            owner_q      <= '0;
            orphan_q     <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            valid_q      <= valid_d;
            owner_q      <= owner_d;
            orphan_q     <= orphan_d;
        end
    end

    assign orphan_err = orphan_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change just after negedge, outputs are checked 1ns later.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic orphan_err;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_bus_if #(.TAG_W(4)) if_b ();
    mem_bus_if #(.TAG_W(4)) dm_b ();
    mem_bus_if #(.TAG_W(4)) mem_b ();

    mem_arbiter #(.STARVE_LIMIT(4), .NUM_TAGS(16)) dut (
        .clk(clk), .rst(rst), .if_bus(if_b), .dm_bus(dm_b), .mem_bus(mem_b), .orphan_err(orphan_err)
    );

    always #5 clk = ~clk;

    task automatic idle();
        if_b.command = 2'd0; if_b.addr = '0; if_b.wdata = '0;
        dm_b.command = 2'd0; dm_b.addr = '0; dm_b.wdata = '0;
        mem_b.response = '0; mem_b.data = '0; mem_b.tag = '0;
    endtask

    task automatic nxt();
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        nxt();
        if_b.command = 2'd1; if_b.addr = 32'h40; mem_b.response = 4'd3; mem_b.tag = 4'd5;
        #1;
        n_tests++; if (mem_b.command !== 2'd0) begin n_fail++; $display("FAIL reset_mem_cmd got %0d want 0", mem_b.command); end
        n_tests++; if (if_b.response !== 4'd0) begin n_fail++; $display("FAIL reset_if_resp got %0d want 0", if_b.response); end
        n_tests++; if (if_b.tag !== 4'd0 || dm_b.tag !== 4'd0) begin n_fail++; $display("FAIL reset_tags got %0d/%0d want 0/0", if_b.tag, dm_b.tag); end
        n_tests++; if (orphan_err !== 1'b0) begin n_fail++; $display("FAIL reset_orphan got %0b want 0", orphan_err); end
        nxt();
        rst = 1'b0;
    endtask

    task automatic test_if_load();
        nxt();
        if_b.command = 2'd1; if_b.addr = 32'h40; mem_b.response = 4'd3;
        #1;
        n_tests++; if (if_b.response !== 4'd3) begin n_fail++; $display("FAIL if_load_resp got %0d want 3", if_b.response); end
        n_tests++; if (mem_b.addr !== 32'h40 || mem_b.command !== 2'd1) begin n_fail++; $display("FAIL if_load_mem got %h/%0d want 40/1", mem_b.addr, mem_b.command); end
        nxt();
        #1;
        n_tests++; if (dm_b.tag !== 4'd0 || if_b.tag !== 4'd0) begin n_fail++; $display("FAIL if_load_quiet got %0d/%0d want 0/0", if_b.tag, dm_b.tag); end
        nxt();
        mem_b.tag = 4'd3; mem_b.data = 32'h00A00093;
        #1;
        n_tests++; if (if_b.tag !== 4'd3 || if_b.data !== 32'h00A00093) begin n_fail++; $display("FAIL if_load_ret got %0d/%h want 3/00a00093", if_b.tag, if_b.data); end
        n_tests++; if (dm_b.tag !== 4'd0 || dm_b.data !== 32'h0) begin n_fail++; $display("FAIL if_load_dm_quiet got %0d/%h want 0/0", dm_b.tag, dm_b.data); end
    endtask

    task automatic test_priority();
        nxt();
        if_b.command = 2'd1; if_b.addr = 32'h40;
        dm_b.command = 2'd1; dm_b.addr = 32'h100; mem_b.response = 4'd5;
        #1;
        n_tests++; if (dm_b.response !== 4'd5) begin n_fail++; $display("FAIL prio_dm_resp got %0d want 5", dm_b.response); end
        n_tests++; if (if_b.response !== 4'd0) begin n_fail++; $display("FAIL prio_if_resp got %0d want 0", if_b.response); end
        n_tests++; if (mem_b.addr !== 32'h100) begin n_fail++; $display("FAIL prio_addr got %h want 100", mem_b.addr); end
        nxt();
        nxt();
        mem_b.tag = 4'd5; mem_b.data = 32'h12345678;
        #1;
        n_tests++; if (dm_b.tag !== 4'd5 || dm_b.data !== 32'h12345678) begin n_fail++; $display("FAIL prio_ret_dm got %0d/%h want 5/12345678", dm_b.tag, dm_b.data); end
        n_tests++; if (if_b.tag !== 4'd0 || if_b.data !== 32'h0) begin n_fail++; $display("FAIL prio_ret_if got %0d/%h want 0/0", if_b.tag, if_b.data); end
    endtask

    task automatic test_starve();
        logic [3:0]  exp_resp;
        logic [31:0] exp_addr;
        for (int k = 1; k <= 6; k++) begin
            nxt();
            if (k <= 5) begin if_b.command = 2'd1; if_b.addr = 32'h80; end
            dm_b.command = 2'd2; dm_b.addr = 32'h300; dm_b.wdata = 32'h5; mem_b.response = 4'd1;
            exp_resp = (k == 5) ? 4'd1 : 4'd0;
            exp_addr = (k == 5) ? 32'h80 : 32'h300;
            #1;
            n_tests++; if (if_b.response !== exp_resp) begin n_fail++; $display("FAIL starve_if_resp cyc %0d got %0d want %0d", k, if_b.response, exp_resp); end
            n_tests++; if (mem_b.addr !== exp_addr) begin n_fail++; $display("FAIL starve_addr cyc %0d got %h want %h", k, mem_b.addr, exp_addr); end
            if (k == 5) begin
                @(posedge clk); #1;
                n_tests++; if (dut.starve_cnt_q !== 3'd0) begin n_fail++; $display("FAIL starve_cnt_clear got %0d want 0", dut.starve_cnt_q); end
            end
        end
    endtask

    task automatic test_store_orphan();
        nxt();
        #1;
        n_tests++; if (orphan_err !== 1'b0) begin n_fail++; $display("FAIL orphan_pre got %0b want 0", orphan_err); end
        dm_b.command = 2'd2; dm_b.addr = 32'h200; dm_b.wdata = 32'hDEADBEEF; mem_b.response = 4'd7;
        #1;
        n_tests++; if (mem_b.wdata !== 32'hDEADBEEF || mem_b.command !== 2'd2) begin n_fail++; $display("FAIL store_mem got %h/%0d want deadbeef/2", mem_b.wdata, mem_b.command); end
        n_tests++; if (dm_b.response !== 4'd7) begin n_fail++; $display("FAIL store_resp got %0d want 7", dm_b.response); end
        nxt();
        mem_b.tag = 4'd7; mem_b.data = 32'hCAFE;
        #1;
        n_tests++; if (if_b.tag !== 4'd0 || dm_b.tag !== 4'd0) begin n_fail++; $display("FAIL store_ret_tags got %0d/%0d want 0/0", if_b.tag, dm_b.tag); end
        nxt();
        #1;
        n_tests++; if (orphan_err !== 1'b1) begin n_fail++; $display("FAIL store_orphan got %0b want 1", orphan_err); end
    endtask

    task automatic test_same_cycle();
        nxt();
        if_b.command = 2'd1; if_b.addr = 32'h44; mem_b.response = 4'd2;
        #1;
        n_tests++; if (if_b.response !== 4'd2) begin n_fail++; $display("FAIL same_if_resp got %0d want 2", if_b.response); end
        nxt();
        dm_b.command = 2'd1; dm_b.addr = 32'h104; mem_b.response = 4'd2;
        mem_b.tag = 4'd2; mem_b.data = 32'h11;
        #1;
        n_tests++; if (if_b.tag !== 4'd2 || if_b.data !== 32'h11) begin n_fail++; $display("FAIL same_if_ret got %0d/%h want 2/11", if_b.tag, if_b.data); end
        n_tests++; if (dm_b.response !== 4'd2 || dm_b.tag !== 4'd0) begin n_fail++; $display("FAIL same_dm got resp %0d tag %0d want 2/0", dm_b.response, dm_b.tag); end
        nxt();
        mem_b.tag = 4'd2; mem_b.data = 32'h22;
        #1;
        n_tests++; if (dm_b.tag !== 4'd2 || dm_b.data !== 32'h22) begin n_fail++; $display("FAIL same_dm_ret got %0d/%h want 2/22", dm_b.tag, dm_b.data); end
        n_tests++; if (if_b.tag !== 4'd0) begin n_fail++; $display("FAIL same_if_quiet got %0d want 0", if_b.tag); end
    endtask

    task automatic test_reset_mid();
        nxt();
        if_b.command = 2'd1; if_b.addr = 32'h48; mem_b.response = 4'd4;
        nxt();
        dm_b.command = 2'd1; dm_b.addr = 32'h108; mem_b.response = 4'd9;
        nxt();
        rst = 1'b1;
        if_b.command = 2'd1; if_b.addr = 32'h4C; mem_b.response = 4'd3; mem_b.tag = 4'd4;
        #1;
        n_tests++; if (mem_b.command !== 2'd0) begin n_fail++; $display("FAIL rstmid_cmd got %0d want 0", mem_b.command); end
        n_tests++; if (if_b.response !== 4'd0 || if_b.tag !== 4'd0) begin n_fail++; $display("FAIL rstmid_if got %0d/%0d want 0/0", if_b.response, if_b.tag); end
        n_tests++; if (orphan_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_orphan_clr got %0b want 0", orphan_err); end
        nxt();
        rst = 1'b0;
        nxt();
        mem_b.tag = 4'd4; mem_b.data = 32'h44;
        #1;
        n_tests++; if (if_b.tag !== 4'd0 || dm_b.tag !== 4'd0) begin n_fail++; $display("FAIL rstmid_drop got %0d/%0d want 0/0", if_b.tag, dm_b.tag); end
        nxt();
        #1;
        n_tests++; if (orphan_err !== 1'b1) begin n_fail++; $display("FAIL rstmid_orphan got %0b want 1", orphan_err); end
    endtask

    initial begin
        idle();
        test_reset();
        test_if_load();
        test_priority();
        test_starve();
        test_store_orphan();
        test_same_cycle();
        test_reset_mid();
        nxt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
